// File: rtl/posit_mul_core.sv
// Posit significand multiplier: sequential shift-add product with scale
// accumulation and single-step normalization, one transaction in flight.
module posit_mul_core #(
    parameter int N  = 8,
    parameter int ES = 4,
    parameter int RS = $clog2(N),
    localparam int MW = N - 3 - ES,
    localparam int SW = RS + ES + 4,
    localparam int FW = 2 * MW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic signed [RS+1:0] a_regime,
    input  logic signed [RS+1:0] b_regime,
    input  logic [ES-1:0]        a_exp,
    input  logic [ES-1:0]        b_exp,
    input  logic [MW-1:0]        a_mant,
    input  logic [MW-1:0]        b_mant,
    input  logic                 a_inf,
    input  logic                 b_inf,
    input  logic                 a_zero,
    input  logic                 b_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 o_sign,
    output logic signed [SW-1:0] o_scale,
    output logic [FW-1:0]        o_mant,
    output logic                 o_inf,
    output logic                 o_zero
);

    localparam int PW = 2 * MW + 2;
    localparam int CW = $clog2(MW + 2);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [MW:0]     mplier_q, mplier_d;
    logic            sign_q, sign_d;
    logic [SW-1:0]   scale_q, scale_d;
    logic [FW-1:0]   mant_q, mant_d;
    logic            inf_q, inf_d;
    logic            zero_q, zero_d;

    // regime*2^ES + exp is a plain concatenation since exp < 2^ES
    logic [SW-1:0]   scl_a, scl_b;
    logic            special;

    assign scl_a   = {{(SW-RS-2-ES){a_regime[RS+1]}}, a_regime, a_exp};
    assign scl_b   = {{(SW-RS-2-ES){b_regime[RS+1]}}, b_regime, b_exp};
    assign special = a_inf | b_inf | a_zero | b_zero;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        scale_d  = scale_q;
        mant_d   = mant_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d    = '0;
                    prod_d   = '0;
                    mant_d   = '0;
                    mcand_d  = {{(PW-MW-1){1'b0}}, 1'b1, a_mant};
                    mplier_d = {1'b1, b_mant};
                    inf_d    = a_inf | b_inf;
                    zero_d   = ~(a_inf | b_inf) & (a_zero | b_zero);
                    if (special) begin
                        sign_d  = 1'b0;
                        scale_d = '0;
                        state_d = DONE;
                    end else begin
                        sign_d  = a_sign ^ b_sign;
                        scale_d = scl_a + scl_b;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(MW)) state_d = NORM;
            end
            NORM: begin
                if (prod_q[PW-1]) begin
                    mant_d  = prod_q[FW-1:0];
                    scale_d = scale_q + SW'(1);
                end else begin
                    mant_d  = {prod_q[FW-2:0], 1'b0};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            scale_q  <= '0;
            mant_q   <= '0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            scale_q  <= scale_d;
            mant_q   <= mant_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
        end
    end

    // Results are only presented while DONE; elsewhere outputs read zero
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign o_sign    = out_valid & sign_q;
    assign o_scale   = out_valid ? scale_q : '0;
    assign o_mant    = out_valid ? mant_q : '0;
    assign o_inf     = out_valid & inf_q;
    assign o_zero    = out_valid & zero_q;

endmodule

// File: tb/tb_posit_mul_core.sv
// Bench for posit_mul_core: fixed table, randomized vectors against an
// arithmetic reference, plus stall, reset and back-to-back sequences.
module tb_posit_mul_core;

    localparam int N  = 8;
    localparam int ES = 4;
    localparam int RS = $clog2(N);
    localparam int MW = N - 3 - ES;
    localparam int SW = RS + ES + 4;
    localparam int FW = 2 * MW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 a_sign = 1'b0, b_sign = 1'b0;
    logic signed [RS+1:0] a_regime = '0, b_regime = '0;
    logic [ES-1:0]        a_exp = '0, b_exp = '0;
    logic [MW-1:0]        a_mant = '0, b_mant = '0;
    logic                 a_inf = 1'b0, b_inf = 1'b0;
    logic                 a_zero = 1'b0, b_zero = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 o_sign;
    logic signed [SW-1:0] o_scale;
    logic [FW-1:0]        o_mant;
    logic                 o_inf, o_zero;

    posit_mul_core #(.N(N), .ES(ES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_regime(a_regime), .b_regime(b_regime),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_mant(a_mant), .b_mant(b_mant),
        .a_inf(a_inf), .b_inf(b_inf),
        .a_zero(a_zero), .b_zero(b_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .o_sign(o_sign), .o_scale(o_scale), .o_mant(o_mant),
        .o_inf(o_inf), .o_zero(o_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit s_a, s_b;
        int r_a, r_b, e_a, e_b, m_a, m_b;
        bit i_a, i_b, z_a, z_b;
        bit x_sign;
        int x_scale, x_mant;
        bit x_inf, x_zero;
    } vec_t;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Value-level reference: multiply the significands as integers and
    // renormalize so the leading one sits just above the FW-bit fraction.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int sa, sb, p, sc;
        r.x_sign = 0; r.x_scale = 0; r.x_mant = 0;
        r.x_inf = 0; r.x_zero = 0;
        if (v.i_a || v.i_b) begin
            r.x_inf = 1;
        end else if (v.z_a || v.z_b) begin
            r.x_zero = 1;
        end else begin
            sa = (1 << MW) + v.m_a;
            sb = (1 << MW) + v.m_b;
            p  = sa * sb;
            sc = v.r_a * (1 << ES) + v.e_a + v.r_b * (1 << ES) + v.e_b;
            if (p >= (1 << (2 * MW + 1))) begin
                sc = sc + 1;
                r.x_mant = p - (1 << (2 * MW + 1));
            end else begin
                r.x_mant = (p - (1 << (2 * MW))) * 2;
            end
            r.x_scale = sc;
            r.x_sign  = v.s_a ^ v.s_b;
        end
        return r;
    endfunction

    function automatic vec_t mk(input bit s_a, s_b, input int r_a, r_b,
                                e_a, e_b, m_a, m_b, input bit i_a, i_b,
                                z_a, z_b, input bit xs, input int xsc, xm,
                                input bit xi, xz);
        vec_t v;
        v.s_a = s_a; v.s_b = s_b; v.r_a = r_a; v.r_b = r_b;
        v.e_a = e_a; v.e_b = e_b; v.m_a = m_a; v.m_b = m_b;
        v.i_a = i_a; v.i_b = i_b; v.z_a = z_a; v.z_b = z_b;
        v.x_sign = xs; v.x_scale = xsc; v.x_mant = xm;
        v.x_inf = xi; v.x_zero = xz;
        return v;
    endfunction

    function automatic vec_t rand_vec(input bit allow_special);
        vec_t v;
        v.s_a = 1'($urandom); v.s_b = 1'($urandom);
        v.r_a = $urandom_range(0, 31) - 16;
        v.r_b = $urandom_range(0, 31) - 16;
        v.e_a = $urandom_range(0, (1 << ES) - 1);
        v.e_b = $urandom_range(0, (1 << ES) - 1);
        v.m_a = $urandom_range(0, (1 << MW) - 1);
        v.m_b = $urandom_range(0, (1 << MW) - 1);
        v.i_a = allow_special && ($urandom_range(0, 7) == 0);
        v.i_b = allow_special && ($urandom_range(0, 7) == 0);
        v.z_a = allow_special && ($urandom_range(0, 7) == 0);
        v.z_b = allow_special && ($urandom_range(0, 7) == 0);
        return model(v);
    endfunction

    task automatic drive(input vec_t v);
        a_sign = v.s_a; b_sign = v.s_b;
        a_regime = v.r_a[RS+1:0]; b_regime = v.r_b[RS+1:0];
        a_exp = v.e_a[ES-1:0]; b_exp = v.e_b[ES-1:0];
        a_mant = v.m_a[MW-1:0]; b_mant = v.m_b[MW-1:0];
        a_inf = v.i_a; b_inf = v.i_b; a_zero = v.z_a; b_zero = v.z_b;
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, " sign"}, o_sign, v.x_sign);
        chk({tag, " scale"}, o_scale, v.x_scale);
        chk({tag, " mant"}, o_mant, v.x_mant);
        chk({tag, " inf"}, o_inf, v.x_inf);
        chk({tag, " zero"}, o_zero, v.x_zero);
    endtask

    // Accept one pair, count edges (acceptance edge = 1) until out_valid.
    task automatic start_and_wait(input vec_t v, output int lat);
        @(negedge clk);
        drive(v);
        chk("ready before accept", in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        drive(rand_vec(1'b1));
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " idle ready"}, in_ready, 1);
        chk({tag, " idle valid"}, out_valid, 0);
    endtask

    vec_t tbl[$];
    vec_t exp_q[$];
    vec_t v, v2;
    int   lat;
    int   bad;

    initial begin
        #2;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset o_scale", o_scale, 0);
        chk("reset o_mant", o_mant, 0);
        chk("reset flags", {o_sign, o_inf, o_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(mk(0,0, 0,0, 1,0, 1,1, 0,0,0,0, 0, 2, 1, 0,0));
        tbl.push_back(mk(1,0, -1,0, 0,3, 0,0, 0,0,0,0, 1, -13, 0, 0,0));
        tbl.push_back(mk(1,1, 3,2, 5,6, 1,0, 1,0,0,1, 0, 0, 0, 1,0));
        tbl.push_back(mk(1,0, 3,2, 5,6, 1,1, 0,0,1,0, 0, 0, 0, 0,1));
        tbl.push_back(mk(0,0, -16,-16, 0,0, 0,0, 0,0,0,0, 0, -512, 0, 0,0));
        tbl.push_back(mk(0,1, 15,15, 15,15, 1,1, 0,0,0,0, 1, 511, 1, 0,0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,1,1,1, 0, 0, 0, 1,0));
        for (int i = 0; i < 24; i++) tbl.push_back(rand_vec(1'b1));

        foreach (tbl[i]) begin
            start_and_wait(tbl[i], lat);
            chk($sformatf("v%0d latency", i), lat,
                (tbl[i].i_a | tbl[i].i_b | tbl[i].z_a | tbl[i].z_b)
                    ? 1 : MW + 3);
            chk_out($sformatf("v%0d", i), tbl[i]);
            release_result($sformatf("v%0d", i));
        end

        // Stall in DONE with a competing request on the input
        v = rand_vec(1'b0);
        start_and_wait(v, lat);
        chk("stall latency", lat, MW + 3);
        v2 = rand_vec(1'b1);
        drive(v2);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall valid", out_valid, 1);
            chk("stall in_ready", in_ready, 0);
            chk_out("stall", v);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stall exit ready", in_ready, 1);
        bad = 0;
        repeat (MW + 5) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad = 1;
        end
        chk("no accept at DONE exit", bad, 0);

        // Reset in the middle of MUL
        @(negedge clk);
        drive(rand_vec(1'b0));
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid-reset in_ready", in_ready, 1);
        chk("mid-reset out_valid", out_valid, 0);
        chk("mid-reset outs", {o_sign, o_scale, o_mant, o_inf, o_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        chk("no result after reset", bad, 0);

        // Back-to-back stream with the consumer always ready
        begin
            int sent = 0, got = 0, last = -1;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
                @(negedge clk);
                if (out_valid) begin
                    if (exp_q.size() > 0) begin
                        chk_out($sformatf("b2b%0d", got), exp_q.pop_front());
                    end
                    if (last >= 0) chk("b2b period", cyc - last, MW + 4);
                    last = cyc;
                    got++;
                end
                in_valid = 1'b0;
                if (in_ready && sent < 6) begin
                    v = rand_vec(1'b0);
                    drive(v);
                    exp_q.push_back(v);
                    in_valid = 1'b1;
                    sent++;
                end
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            chk("b2b result count", got, 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
